// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues I-cache reads, delivers PC/instruction into IF-ID; optional FETCH_COUNT_EN adds fetch_count.
// Latency: 1 cycle from i_ready to valid_out. Backpressure: stall_in holds outputs; one-entry skid absorbs an in-flight response.

`ifndef INST_FLUSHED
`define INST_FLUSHED 16'h7C00
`endif

module inst_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        i_req,
    output logic [15:0] i_addr,
    input  logic        i_ready,
    input  logic [15:0] i_data,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        stall_in,
    output logic [15:0] PC_out,
    output logic [15:0] PC_next_seq_out,
    output logic [15:0] inst_out,
    output logic        valid_out,
    output logic        fetch_stall
`ifdef FETCH_COUNT_EN
    ,
    output logic [15:0] fetch_count
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DRAIN = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] inst;
    } fetch_ent_t;

    state_t     state_q,    state_d;
    logic [15:0] req_addr_q, req_addr_d;
    logic [15:0] pend_pc_q,  pend_pc_d;
    logic        out_vld_q,  out_vld_d;
    fetch_ent_t  out_q,      out_d;
    logic        skid_vld_q, skid_vld_d;
    fetch_ent_t  skid_q,     skid_d;

    fetch_ent_t  rsp_ent;
    logic        consume;

    assign rsp_ent = '{pc: req_addr_q, inst: i_data};
    assign consume = out_vld_q && !stall_in;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_FETCH;
            req_addr_q <= RESET_PC;
            pend_pc_q  <= 16'h0000;
            out_vld_q  <= 1'b0;
            out_q      <= '0;
            skid_vld_q <= 1'b0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            pend_pc_q  <= pend_pc_d;
            out_vld_q  <= out_vld_d;
            out_q      <= out_d;
            skid_vld_q <= skid_vld_d;
            skid_q     <= skid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        pend_pc_d  = pend_pc_q;
        out_vld_d  = out_vld_q;
        out_d      = out_q;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;

        case (state_q)
            S_FETCH: begin
                if (redirect) begin
                    out_vld_d  = 1'b0;
                    skid_vld_d = 1'b0;
                    if (i_ready) begin
                        req_addr_d = redirect_pc;
                    end else begin
                        // request still in flight: wait for it before retargeting
                        pend_pc_d = redirect_pc;
                        state_d   = S_DRAIN;
                    end
                end else if (i_ready) begin
                    req_addr_d = req_addr_q + 16'd1;
                    if (!out_vld_q || !stall_in) begin
                        out_d     = rsp_ent;
                        out_vld_d = 1'b1;
                    end else begin
                        skid_d     = rsp_ent;
                        skid_vld_d = 1'b1;
                        state_d    = S_HOLD;
                    end
                end else if (consume) begin
                    out_vld_d = 1'b0;
                end
            end

            S_DRAIN: begin
                if (redirect) begin
                    out_vld_d  = 1'b0;
                    skid_vld_d = 1'b0;
                    pend_pc_d  = redirect_pc;
                end else if (consume) begin
                    out_vld_d = 1'b0;
                end
                if (i_ready) begin
                    req_addr_d = redirect ? redirect_pc : pend_pc_q;
                    state_d    = S_FETCH;
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    out_vld_d  = 1'b0;
                    skid_vld_d = 1'b0;
                    req_addr_d = redirect_pc;
                    state_d    = S_FETCH;
                end else if (!stall_in) begin
                    out_d      = skid_q;
                    skid_vld_d = 1'b0;
                    state_d    = S_FETCH;
                end
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign i_req           = reset_n && (state_q != S_HOLD);
    assign i_addr          = req_addr_q;
    assign valid_out       = out_vld_q;
    assign PC_out          = out_vld_q ? out_q.pc : 16'h0000;
    assign PC_next_seq_out = out_vld_q ? (out_q.pc + 16'd1) : 16'h0000;
    assign inst_out        = out_vld_q ? out_q.inst : `INST_FLUSHED;
    assign fetch_stall     = reset_n && !out_vld_q;

`ifdef FETCH_COUNT_EN
    logic [15:0] fetch_count_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_count_q <= 16'h0000;
        end else if (out_vld_q && !stall_in && !redirect) begin
            fetch_count_q <= fetch_count_q + 16'd1;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: sequential fetch, skid/hold, drain, redirect priority, wrap, reset, optional counter.

`ifndef INST_FLUSHED
`define INST_FLUSHED 16'h7C00
`endif

module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_ready;
    logic [15:0] i_data;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        stall_in;
    logic [15:0] PC_out;
    logic [15:0] PC_next_seq_out;
    logic [15:0] inst_out;
    logic        valid_out;
    logic        fetch_stall;
`ifdef FETCH_COUNT_EN
    logic [15:0] fetch_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    inst_fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_req           (i_req),
        .i_addr          (i_addr),
        .i_ready         (i_ready),
        .i_data          (i_data),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .stall_in        (stall_in),
        .PC_out          (PC_out),
        .PC_next_seq_out (PC_next_seq_out),
        .inst_out        (inst_out),
        .valid_out       (valid_out),
        .fetch_stall     (fetch_stall)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count     (fetch_count)
`endif
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; i_ready = 1'b0; i_data = 16'h0000;
        redirect = 1'b0; redirect_pc = 16'h0000; stall_in = 1'b0;
        cyc; cyc;
        n_checks++; if (i_req !== 1'b0) begin n_fail++; $display("FAIL rst_i_req got %b exp 0", i_req); end
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", valid_out); end
        n_checks++; if (PC_out !== 16'h0000) begin n_fail++; $display("FAIL rst_pc got %h exp 0000", PC_out); end
        n_checks++; if (PC_next_seq_out !== 16'h0000) begin n_fail++; $display("FAIL rst_pc_next got %h exp 0000", PC_next_seq_out); end
        n_checks++; if (inst_out !== `INST_FLUSHED) begin n_fail++; $display("FAIL rst_inst got %h exp %h", inst_out, `INST_FLUSHED); end
        n_checks++; if (i_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_i_addr got %h exp 0000", i_addr); end
        n_checks++; if (fetch_stall !== 1'b0) begin n_fail++; $display("FAIL rst_fetch_stall got %b exp 0", fetch_stall); end
        reset_n = 1'b1;
        #1;
        n_checks++; if (i_req !== 1'b1) begin n_fail++; $display("FAIL post_rst_i_req got %b exp 1", i_req); end
        n_checks++; if (fetch_stall !== 1'b1) begin n_fail++; $display("FAIL post_rst_fetch_stall got %b exp 1", fetch_stall); end
    endtask

    task automatic test_sequential;
        i_ready = 1'b1; i_data = 16'hA000;
        cyc;
        n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL seq0_valid got %b exp 1", valid_out); end
        n_checks++; if (PC_out !== 16'h0000) begin n_fail++; $display("FAIL seq0_pc got %h exp 0000", PC_out); end
        n_checks++; if (inst_out !== 16'hA000) begin n_fail++; $display("FAIL seq0_inst got %h exp A000", inst_out); end
        n_checks++; if (PC_next_seq_out !== 16'h0001) begin n_fail++; $display("FAIL seq0_next got %h exp 0001", PC_next_seq_out); end
        n_checks++; if (i_addr !== 16'h0001) begin n_fail++; $display("FAIL seq0_i_addr got %h exp 0001", i_addr); end
        i_data = 16'hA001;
        cyc;
        n_checks++; if (PC_out !== 16'h0001) begin n_fail++; $display("FAIL seq1_pc got %h exp 0001", PC_out); end
        n_checks++; if (inst_out !== 16'hA001) begin n_fail++; $display("FAIL seq1_inst got %h exp A001", inst_out); end
        n_checks++; if (PC_next_seq_out !== 16'h0002) begin n_fail++; $display("FAIL seq1_next got %h exp 0002", PC_next_seq_out); end
        i_data = 16'hA002;
        cyc;
        n_checks++; if (PC_out !== 16'h0002) begin n_fail++; $display("FAIL seq2_pc got %h exp 0002", PC_out); end
        n_checks++; if (inst_out !== 16'hA002) begin n_fail++; $display("FAIL seq2_inst got %h exp A002", inst_out); end
        n_checks++; if (i_addr !== 16'h0003) begin n_fail++; $display("FAIL seq2_i_addr got %h exp 0003", i_addr); end
        i_ready = 1'b0;
        cyc;
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL seq_drop_valid got %b exp 0", valid_out); end
        n_checks++; if (PC_out !== 16'h0000) begin n_fail++; $display("FAIL seq_drop_pc got %h exp 0000", PC_out); end
        n_checks++; if (inst_out !== `INST_FLUSHED) begin n_fail++; $display("FAIL seq_drop_inst got %h exp %h", inst_out, `INST_FLUSHED); end
    endtask

    task automatic test_skid;
        redirect = 1'b1; redirect_pc = 16'h0005; i_ready = 1'b1; i_data = 16'hFFFF;
        cyc;
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL skid_redir_valid got %b exp 0", valid_out); end
        n_checks++; if (i_addr !== 16'h0005) begin n_fail++; $display("FAIL skid_redir_addr got %h exp 0005", i_addr); end
        redirect = 1'b0; i_data = 16'hB005;
        cyc;
        n_checks++; if (PC_out !== 16'h0005) begin n_fail++; $display("FAIL skid_pc5 got %h exp 0005", PC_out); end
        stall_in = 1'b1; i_data = 16'hB006;
        cyc;
        n_checks++; if (PC_out !== 16'h0005) begin n_fail++; $display("FAIL skid_hold_pc got %h exp 0005", PC_out); end
        n_checks++; if (inst_out !== 16'hB005) begin n_fail++; $display("FAIL skid_hold_inst got %h exp B005", inst_out); end
        n_checks++; if (i_req !== 1'b0) begin n_fail++; $display("FAIL skid_hold_i_req got %b exp 0", i_req); end
        n_checks++; if (i_addr !== 16'h0007) begin n_fail++; $display("FAIL skid_hold_i_addr got %h exp 0007", i_addr); end
        i_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cyc;
            n_checks++; if (PC_out !== 16'h0005 || valid_out !== 1'b1) begin n_fail++; $display("FAIL skid_frozen%0d got pc %h vld %b exp 0005/1", k, PC_out, valid_out); end
            n_checks++; if (i_req !== 1'b0) begin n_fail++; $display("FAIL skid_frozen_i_req%0d got %b exp 0", k, i_req); end
        end
        stall_in = 1'b0;
        cyc;
        n_checks++; if (PC_out !== 16'h0006) begin n_fail++; $display("FAIL skid_release_pc got %h exp 0006", PC_out); end
        n_checks++; if (inst_out !== 16'hB006) begin n_fail++; $display("FAIL skid_release_inst got %h exp B006", inst_out); end
        n_checks++; if (i_req !== 1'b1) begin n_fail++; $display("FAIL skid_release_i_req got %b exp 1", i_req); end
        cyc;
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL skid_empty_valid got %b exp 0", valid_out); end
    endtask

    task automatic test_drain;
        redirect = 1'b1; redirect_pc = 16'h0008; i_ready = 1'b1;
        cyc;
        n_checks++; if (i_addr !== 16'h0008) begin n_fail++; $display("FAIL drain_setup_addr got %h exp 0008", i_addr); end
        i_ready = 1'b0; redirect_pc = 16'h0020;
        cyc;
        n_checks++; if (i_addr !== 16'h0008) begin n_fail++; $display("FAIL drain_addr_stable got %h exp 0008", i_addr); end
        n_checks++; if (i_req !== 1'b1) begin n_fail++; $display("FAIL drain_i_req got %b exp 1", i_req); end
        redirect = 1'b0;
        cyc;
        n_checks++; if (i_addr !== 16'h0008) begin n_fail++; $display("FAIL drain_addr_wait got %h exp 0008", i_addr); end
        i_ready = 1'b1; i_data = 16'hDEAD;
        cyc;
        n_checks++; if (i_addr !== 16'h0020) begin n_fail++; $display("FAIL drain_new_addr got %h exp 0020", i_addr); end
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL drain_discard_valid got %b exp 0", valid_out); end
        i_ready = 1'b0;
        cyc;
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL drain_after_valid got %b exp 0", valid_out); end
        redirect = 1'b1; redirect_pc = 16'h0030;
        cyc;
        redirect_pc = 16'h0031;
        cyc;
        redirect = 1'b0; i_ready = 1'b1;
        cyc;
        n_checks++; if (i_addr !== 16'h0031) begin n_fail++; $display("FAIL drain_latest_wins got %h exp 0031", i_addr); end
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL drain_latest_valid got %b exp 0", valid_out); end
        i_ready = 1'b0;
    endtask

    task automatic test_redirect_stall;
        redirect = 1'b1; redirect_pc = 16'h0040; i_ready = 1'b1;
        cyc;
        redirect = 1'b0; i_data = 16'hC040;
        cyc;
        i_ready = 1'b0; stall_in = 1'b1;
        cyc;
        n_checks++; if (PC_out !== 16'h0040 || valid_out !== 1'b1) begin n_fail++; $display("FAIL rs_hold got pc %h vld %b exp 0040/1", PC_out, valid_out); end
        n_checks++; if (inst_out !== 16'hC040) begin n_fail++; $display("FAIL rs_hold_inst got %h exp C040", inst_out); end
        redirect = 1'b1; redirect_pc = 16'h0050; i_ready = 1'b1; i_data = 16'hC041;
        cyc;
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rs_valid got %b exp 0", valid_out); end
        n_checks++; if (inst_out !== `INST_FLUSHED) begin n_fail++; $display("FAIL rs_inst got %h exp %h", inst_out, `INST_FLUSHED); end
        n_checks++; if (PC_out !== 16'h0000) begin n_fail++; $display("FAIL rs_pc got %h exp 0000", PC_out); end
        n_checks++; if (PC_next_seq_out !== 16'h0000) begin n_fail++; $display("FAIL rs_next got %h exp 0000", PC_next_seq_out); end
        n_checks++; if (i_addr !== 16'h0050) begin n_fail++; $display("FAIL rs_i_addr got %h exp 0050", i_addr); end
        n_checks++; if (fetch_stall !== 1'b1) begin n_fail++; $display("FAIL rs_fetch_stall got %b exp 1", fetch_stall); end
        redirect = 1'b0; stall_in = 1'b0; i_ready = 1'b0;
    endtask

    task automatic test_wrap;
        redirect = 1'b1; redirect_pc = 16'hFFFF; i_ready = 1'b1;
        cyc;
        redirect = 1'b0; i_data = 16'hE0FF;
        cyc;
        n_checks++; if (PC_out !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_pc got %h exp FFFF", PC_out); end
        n_checks++; if (PC_next_seq_out !== 16'h0000) begin n_fail++; $display("FAIL wrap_next got %h exp 0000", PC_next_seq_out); end
        n_checks++; if (i_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_i_addr got %h exp 0000", i_addr); end
        i_ready = 1'b0;
        cyc;
    endtask

    task automatic test_reset_mid;
        redirect = 1'b1; redirect_pc = 16'h0060; i_ready = 1'b1;
        cyc;
        redirect = 1'b0; i_ready = 1'b0;
        cyc;
        reset_n = 1'b0; i_ready = 1'b1; i_data = 16'h1234;
        cyc;
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b exp 0", valid_out); end
        n_checks++; if (i_req !== 1'b0) begin n_fail++; $display("FAIL rmid_i_req got %b exp 0", i_req); end
        n_checks++; if (i_addr !== 16'h0000) begin n_fail++; $display("FAIL rmid_i_addr got %h exp 0000", i_addr); end
        reset_n = 1'b1; i_ready = 1'b0;
        #1;
        n_checks++; if (i_req !== 1'b1) begin n_fail++; $display("FAIL rmid_req_after got %b exp 1", i_req); end
        i_ready = 1'b1; i_data = 16'h5678;
        cyc;
        n_checks++; if (PC_out !== 16'h0000 || inst_out !== 16'h5678) begin n_fail++; $display("FAIL rmid_first got pc %h inst %h exp 0000/5678", PC_out, inst_out); end
        i_ready = 1'b0;
        cyc;
    endtask

`ifdef FETCH_COUNT_EN
    task automatic test_fetch_count;
        reset_n = 1'b0;
        cyc;
        n_checks++; if (fetch_count !== 16'h0000) begin n_fail++; $display("FAIL fc_reset got %h exp 0000", fetch_count); end
        reset_n = 1'b1;
        i_ready = 1'b1; i_data = 16'hD000;
        cyc;
        i_data = 16'hD001;
        cyc;
        n_checks++; if (fetch_count !== 16'h0001) begin n_fail++; $display("FAIL fc_one got %h exp 0001", fetch_count); end
        stall_in = 1'b1; i_ready = 1'b0;
        cyc;
        n_checks++; if (fetch_count !== 16'h0001) begin n_fail++; $display("FAIL fc_stalled got %h exp 0001", fetch_count); end
        stall_in = 1'b0; i_ready = 1'b1; i_data = 16'hD002;
        cyc;
        i_data = 16'hD003;
        cyc;
        i_ready = 1'b0;
        cyc;
        n_checks++; if (fetch_count !== 16'h0004) begin n_fail++; $display("FAIL fc_four got %h exp 0004", fetch_count); end
        i_ready = 1'b1;
        cyc;
        cyc;
        reset_n = 1'b0; i_ready = 1'b0;
        cyc;
        n_checks++; if (fetch_count !== 16'h0000) begin n_fail++; $display("FAIL fc_mid_reset got %h exp 0000", fetch_count); end
        reset_n = 1'b1;
        cyc;
    endtask
`endif

    initial begin
        test_reset;
        test_sequential;
        test_skid;
        test_drain;
        test_redirect_stall;
        test_wrap;
        test_reset_mid;
`ifdef FETCH_COUNT_EN
        test_fetch_count;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
